i2s_adc_rx: RTL and testbench
=============================

Name: i2s_adc_rx

Overview:
- Receive side of the WM8731 digital audio interface: deserializes the codec ADC stream (AUD_ADCDAT) into parallel stereo sample pairs.
- Complements the existing DAC transmit path. The FPGA remains bit-clock/LR-clock master, and this block only observes BCLK/ADCLRCK.
- Sits between the codec pins and the synthesizer's audio processing chain (input monitor/effects). Delivers samples through a valid/ready handshake in the clk domain.

Parameters:
- SAMPLE_W, 16, bits captured per channel, MSB first; supported range 8..32.
- SYNC_STAGES, 2, synchronizer flops on each codec input pin; minimum 2.

Ports:
- clk  input  1  system clock (CLOCK_50 domain); must run at least 4x BCLK.
- rst_n  input  1  asynchronous active-low reset.
- en_i  input  1  receive enable; low forces resynchronization.
- bclk_i  input  1  AUD_BCLK as seen at the pin (asynchronous to clk).
- lrck_i  input  1  AUD_ADCLRCK; low = left, high = right (I2S mode).
- adcdat_i  input  1  AUD_ADCDAT serial data.
- left_o  output  SAMPLE_W  left sample, two's complement.
- right_o  output  SAMPLE_W  right sample, two's complement.
- valid_o  output  1  sample pair available.
- ready_i  input  1  downstream accepts the pair.
- overrun_o  output  1  one-cycle pulse: completed pair dropped.
- frame_err_o  output  1  one-cycle pulse: channel word shorter than SAMPLE_W.

Behaviour:
- Reset values: left_o=0, right_o=0, valid_o=0, overrun_o=0, frame_err_o=0, FSM=SYNC, all shift registers and counters = 0.
- Pin conditioning:
  - bclk_i, lrck_i and adcdat_i each pass through SYNC_STAGES flops plus one history flop.
  - A BCLK rise event (bclk_rise) is a 1-cycle strobe: sync=1 and history=0.
  - Every action below happens only on bclk_rise cycles, using the synchronized lrck/dat values of that cycle.
  - prev_lr holds lrck as sampled at the previous bclk_rise.
- FSM states:
  - SYNC: ignore data. On bclk_rise with prev_lr=1 and lrck=0, go to LEFT with bitcnt=0 and skip=1 (I2S one-bit delay slot).
  - LEFT:
    - On bclk_rise with skip=1, clear skip and discard the bit.
    - Otherwise, if bitcnt<SAMPLE_W, shift dat into the left shift register MSB-first and increment bitcnt. Extra bits beyond SAMPLE_W are ignored.
    - On bclk_rise with lrck=1, go to RIGHT, set skip=1, bitcnt=0.
  - RIGHT:
    - Same capture rules into the right shift register.
    - When bitcnt reaches SAMPLE_W, the pair completes on that cycle.
    - On bclk_rise with lrck=0, go to LEFT (new frame).
- Short word: if lrck toggles while bitcnt<SAMPLE_W and skip=0:
  - pulse frame_err_o;
  - zero-fill the missing LSBs (left-justify);
  - a short right word completes the pair at the toggle.
- Pair completion:
  - If valid_o=0 or ready_i=1: register the pair into left_o/right_o and set valid_o=1 on the next cycle.
  - Otherwise: drop the new pair, leave outputs unchanged, pulse overrun_o.
- Handshake:
  - A transfer occurs when valid_o and ready_i are both high at a clk edge.
  - valid_o clears after the transfer unless a new pair loads in the same cycle, in which case valid_o stays 1 with the new data and no overrun.
  - Outputs hold stable while valid_o=1 and ready_i=0.
- Latency: valid_o rises exactly SYNC_STAGES+2 clk cycles after the bclk_i pin rise carrying the right LSB (4 at default).
- en_i=0: FSM goes to SYNC and shift registers and counters clear. Output registers and valid_o are unaffected, so a pending pair can still be read. Capture resumes at the next LR falling edge after en_i=1.
- Reset mid-frame: all state clears immediately. The first pair is emitted only after a full left+right frame following resync.
- Width rule: bitcnt is $clog2(SAMPLE_W+1) bits and saturates at SAMPLE_W.

Decomposition:
- Shared package i2s_pkg holds:
  - state enum (SYNC, LEFT, RIGHT);
  - channel typedef (CH_LEFT=0, CH_RIGHT=1);
  - default SAMPLE_W constant, shared with the DAC transmitter.
- One natural sub-module: i2s_pin_sync (SYNC_STAGES synchronizer, history flop, rise/fall strobes). It is instantiated once per codec input and is reusable by the DAC side for BCLK/DACLRCK monitoring.

Test Plan:
- Nominal frame:
  - Stimulus: BCLK=clk/8, 32 BCLK per channel, left=16'hA5C3, right=16'h3C5A, ready_i=1.
  - Response: one valid_o pulse with left_o=A5C3, right_o=3C5A, 4 clk after the right LSB BCLK rise.
- Startup sync:
  - Stimulus: release reset mid-right-channel.
  - Response: no valid_o until after the next complete frame; first pair equals that frame's data.
- Backpressure:
  - Stimulus: ready_i=0 across two frames (1111/2222, then 3333/4444).
  - Response: outputs hold 1111/2222; overrun_o pulses once at the second completion; after ready_i=1 the next frame loads normally.
- Simultaneous accept and load:
  - Stimulus: raise ready_i exactly on the completion cycle of the next pair.
  - Response: valid_o stays 1, data switches to the new pair, overrun_o=0.
- Short word:
  - Stimulus: only 12 BCLK in the left channel, MSBs 12'hABC.
  - Response: frame_err_o pulses once; left_o=16'hABC0.
- Enable toggle:
  - Stimulus: drop en_i mid-left word for 20 clk.
  - Response: no pair emitted for that frame; capture correct from the following LR falling edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the WM8731 digital audio interface (ADC receive and DAC transmit).
// Holds the receiver state encoding, channel naming and the default sample width.
package i2s_pkg;

  localparam int I2S_SAMPLE_W = 16;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  // I2S mode: LRCK low selects the left channel, high selects the right.
  function automatic channel_e lr_channel(input logic lrck);
    return lrck ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_pin_sync.sv
// Brings one asynchronous codec pin into the clk domain: STAGES synchronizer flops
// plus a history flop, giving a clean level and single-cycle rise/fall strobes.
module i2s_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// WM8731 ADC receive path: observes BCLK/ADCLRCK driven by the FPGA, deserializes
// AUD_ADCDAT into stereo pairs and hands them downstream over valid/ready.
module i2s_adc_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = I2S_SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                bclk_i,
  input  logic                lrck_i,
  input  logic                adcdat_i,
  output logic [SAMPLE_W-1:0] left_o,
  output logic [SAMPLE_W-1:0] right_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                overrun_o,
  output logic                frame_err_o
);

  localparam int              CNT_W   = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_W);

  // Pin conditioning: index 0 = BCLK, 1 = LRCK, 2 = DAT.
  logic [2:0] pin_raw;
  logic [2:0] lvl_s;
  logic [2:0] rise_s;
  logic [2:0] fall_s;
  logic       sync_unused;

  assign pin_raw = {adcdat_i, lrck_i, bclk_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pin
      i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (pin_raw[gi]),
        .level_o(lvl_s[gi]),
        .rise_o (rise_s[gi]),
        .fall_o (fall_s[gi])
      );
    end
  endgenerate

  assign sync_unused = ^{lvl_s[0], rise_s[2:1], fall_s};

  logic bclk_rise;
  logic lrck_s;
  logic dat_s;
  assign bclk_rise = rise_s[0];
  assign lrck_s    = lvl_s[1];
  assign dat_s     = lvl_s[2];

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 skip_q, skip_d;
  logic                 prev_lr_q, prev_lr_d;
  logic [SAMPLE_W-1:0]  left_sr_q, left_sr_d;
  logic [SAMPLE_W-1:0]  right_sr_q, right_sr_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 toggle;
  logic                 short_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      bitcnt_q   <= '0;
      skip_q     <= 1'b0;
      prev_lr_q  <= 1'b0;
      left_sr_q  <= '0;
      right_sr_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      skip_q     <= skip_d;
      prev_lr_q  <= prev_lr_d;
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    skip_d     = skip_q;
    prev_lr_d  = prev_lr_q;
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    toggle     = 1'b0;
    short_word = 1'b0;

    if (!en_i) begin
      state_d    = SYNC;
      bitcnt_d   = '0;
      skip_d     = 1'b0;
      prev_lr_d  = 1'b0;
      left_sr_d  = '0;
      right_sr_d = '0;
    end else if (bclk_rise) begin
      prev_lr_d = lrck_s;
      case (state_q)
        SYNC: begin
          if (prev_lr_q && !lrck_s) begin
            state_d  = LEFT;
            bitcnt_d = '0;
            skip_d   = 1'b1;
          end
        end
        LEFT, RIGHT: begin
          toggle     = (state_q == LEFT) ? (lr_channel(lrck_s) == CH_RIGHT)
                                         : (lr_channel(lrck_s) == CH_LEFT);
          short_word = !skip_q && (bitcnt_q < CNT_MAX);
          if (toggle) begin
            // A truncated word is left-justified so the missing LSBs read as zero.
            if (short_word) begin
              ferr_d = 1'b1;
              if (state_q == LEFT) begin
                left_sr_d = left_sr_q << (CNT_MAX - bitcnt_q);
              end else begin
                right_sr_d = right_sr_q << (CNT_MAX - bitcnt_q);
                done_d     = 1'b1;
              end
            end
            state_d  = (state_q == LEFT) ? RIGHT : LEFT;
            skip_d   = 1'b1;
            bitcnt_d = '0;
          end else if (skip_q) begin
            skip_d = 1'b0;
          end else if (bitcnt_q < CNT_MAX) begin
            bitcnt_d = bitcnt_q + 1'b1;
            if (state_q == LEFT) begin
              left_sr_d = {left_sr_q[SAMPLE_W-2:0], dat_s};
            end else begin
              right_sr_d = {right_sr_q[SAMPLE_W-2:0], dat_s};
              done_d     = (bitcnt_q == CNT_MAX - 1'b1);
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Output holding register: a completed pair loads if the slot is free or being drained.
  logic [SAMPLE_W-1:0] left_q, right_q;
  logic                valid_q, ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || ready_i) begin
          left_q  <= left_sr_q;
          right_q <= right_sr_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign left_o      = left_q;
  assign right_o     = right_q;
  assign valid_o     = valid_q;
  assign overrun_o   = ovr_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: drives BCLK = clk/8 I2S frames from tables and
// hand-written sequences, and checks pairs, handshake, overrun and framing errors.
module tb_i2s_adc_rx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en_i = 1'b1;
  logic         bclk_i = 1'b0;
  logic         lrck_i = 1'b1;
  logic         adcdat_i = 1'b0;
  logic         ready_i = 1'b1;
  logic [W-1:0] left_o, right_o;
  logic         valid_o, overrun_o, frame_err_o;

  i2s_adc_rx #(.SAMPLE_W(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .bclk_i     (bclk_i),
    .lrck_i     (lrck_i),
    .adcdat_i   (adcdat_i),
    .left_o     (left_o),
    .right_o    (right_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overrun_o  (overrun_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: ready_i only changes just after posedge, so negedge values predict the next edge.
  int       n_xfer = 0, n_ovr = 0, n_ferr = 0, n_vfall = 0, rise_cyc = 0;
  logic [W-1:0] xl = '0, xr = '0;
  logic     vprev = 1'b0;
  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      n_xfer++;
      xl = left_o;
      xr = right_o;
    end
    if (valid_o && !vprev) rise_cyc = cyc;
    if (!valid_o && vprev) n_vfall++;
    if (overrun_o) n_ovr++;
    if (frame_err_o) n_ferr++;
    vprev = valid_o;
  end

  int errors = 0, checks = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int lsb_cyc = 0;
  bit ack_at_lsb = 1'b0;

  // One BCLK period: LRCK/DAT change on the falling edge, receiver samples on the rise.
  task automatic bit_cycle(input logic lr, input logic d, input bit is_lsb);
    @(posedge clk); #1;
    bclk_i = 1'b0; lrck_i = lr; adcdat_i = d;
    repeat (4) @(posedge clk); #1;
    bclk_i = 1'b1;
    if (is_lsb) lsb_cyc = cyc;
    if (is_lsb && ack_at_lsb) begin
      ack_at_lsb = 1'b0;
      repeat (3) @(posedge clk); #1;
      ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("simul_valid", 32'(valid_o), 32'd1);
      check("simul_left", 32'(left_o), 32'h9999);
      check("simul_right", 32'(right_o), 32'hAAAA);
      check("simul_overrun", 32'(overrun_o), 32'd0);
    end else begin
      repeat (3) @(posedge clk);
    end
  endtask

  // Rise 0 carries the LRCK change, rise 1 is the discarded delay slot, then nb bits MSB first.
  task automatic send_slot(input logic lr, input logic [W-1:0] word, input int nb, input int len);
    for (int i = 0; i < len; i++) begin
      logic d;
      if (i == 0) d = 1'b0;
      else if (i == 1) d = 1'b1;
      else if (i - 2 < nb) d = word[W-1-(i-2)];
      else d = 1'b1;
      bit_cycle(lr, d, lr && (i - 2 == nb - 1));
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_slot(1'b0, l, W, 32);
    send_slot(1'b1, r, W, 32);
  endtask

  typedef struct {
    logic [W-1:0] l;
    int           nb_l;
    logic [W-1:0] r;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
    int           exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int x0, o0, f0, vf0;
    vecs[0] = '{l: 16'hA5C3, nb_l: 16, r: 16'h3C5A, exp_l: 16'hA5C3, exp_r: 16'h3C5A, exp_ferr: 0};
    vecs[1] = '{l: 16'h0000, nb_l: 16, r: 16'hFFFF, exp_l: 16'h0000, exp_r: 16'hFFFF, exp_ferr: 0};
    vecs[2] = '{l: 16'h8000, nb_l: 16, r: 16'h7FFF, exp_l: 16'h8000, exp_r: 16'h7FFF, exp_ferr: 0};
    vecs[3] = '{l: 16'hABCF, nb_l: 12, r: 16'h1357, exp_l: 16'hABC0, exp_r: 16'h1357, exp_ferr: 1};
    vecs[4] = '{l: 16'h1234, nb_l: 16, r: 16'hFEDC, exp_l: 16'h1234, exp_r: 16'hFEDC, exp_ferr: 0};

    // Reset held through the first part of a right channel, released mid-channel.
    for (int i = 0; i < 10; i++) bit_cycle(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_left", 32'(left_o), 32'd0);
    check("rst_right", 32'(right_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_frame_err", 32'(frame_err_o), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) bit_cycle(1'b1, 1'b0, 1'b0);
    check("startup_no_pair", 32'(n_xfer), 32'd0);

    for (int v = 0; v < 5; v++) begin
      x0 = n_xfer;
      f0 = n_ferr;
      send_slot(1'b0, vecs[v].l, vecs[v].nb_l, (vecs[v].nb_l == W) ? 32 : vecs[v].nb_l + 2);
      send_slot(1'b1, vecs[v].r, W, 32);
      $display("frame %0d: left=%h right=%h (expect %h/%h) frame_err=%0d",
               v, xl, xr, vecs[v].exp_l, vecs[v].exp_r, n_ferr - f0);
      check("vec_xfer_count", 32'(n_xfer - x0), 32'd1);
      check("vec_left", 32'(xl), 32'(vecs[v].exp_l));
      check("vec_right", 32'(xr), 32'(vecs[v].exp_r));
      check("vec_frame_err", 32'(n_ferr - f0), 32'(vecs[v].exp_ferr));
      check("vec_latency", 32'(rise_cyc - lsb_cyc), 32'd4);
    end
    check("no_overrun_so_far", 32'(n_ovr), 32'd0);

    // Backpressure across two frames.
    @(posedge clk); #1; ready_i = 1'b0;
    x0 = n_xfer;
    o0 = n_ovr;
    send_frame(16'h1111, 16'h2222);
    @(negedge clk);
    $display("backpressure frame 1: valid=%0d left=%h right=%h", valid_o, left_o, right_o);
    check("bp_valid", 32'(valid_o), 32'd1);
    check("bp_left1", 32'(left_o), 32'h1111);
    check("bp_right1", 32'(right_o), 32'h2222);
    send_frame(16'h3333, 16'h4444);
    @(negedge clk);
    $display("backpressure frame 2: left=%h right=%h overruns=%0d", left_o, right_o, n_ovr - o0);
    check("bp_hold_left", 32'(left_o), 32'h1111);
    check("bp_hold_right", 32'(right_o), 32'h2222);
    check("bp_overrun", 32'(n_ovr - o0), 32'd1);
    check("bp_no_xfer", 32'(n_xfer - x0), 32'd0);
    @(posedge clk); #1; ready_i = 1'b1;
    send_frame(16'h5555, 16'h6666);
    $display("backpressure release: xfers=%0d last=%h/%h", n_xfer - x0, xl, xr);
    check("bp_xfer_count", 32'(n_xfer - x0), 32'd2);
    check("bp_left3", 32'(xl), 32'h5555);
    check("bp_right3", 32'(xr), 32'h6666);
    check("bp_overrun_total", 32'(n_ovr - o0), 32'd1);

    // Accept of a pending pair on the same edge the next pair loads.
    @(posedge clk); #1; ready_i = 1'b0;
    send_frame(16'h7777, 16'h8888);
    @(negedge clk);
    check("simul_pending", 32'(valid_o), 32'd1);
    o0 = n_ovr;
    vf0 = n_vfall;
    x0 = n_xfer;
    ack_at_lsb = 1'b1;
    send_frame(16'h9999, 16'hAAAA);
    $display("simultaneous: xfers=%0d valid_falls=%0d overruns=%0d", n_xfer - x0, n_vfall - vf0, n_ovr - o0);
    check("simul_no_overrun", 32'(n_ovr - o0), 32'd0);
    check("simul_one_fall", 32'(n_vfall - vf0), 32'd1);
    check("simul_xfers", 32'(n_xfer - x0), 32'd2);

    // Short right word completes the pair at the next LRCK fall.
    x0 = n_xfer;
    f0 = n_ferr;
    send_slot(1'b0, 16'h2468, W, 32);
    send_slot(1'b1, 16'hB5C0, 10, 12);
    send_slot(1'b0, 16'h0F0F, W, 32);
    $display("short right: left=%h right=%h frame_err=%0d", xl, xr, n_ferr - f0);
    check("sr_xfer", 32'(n_xfer - x0), 32'd1);
    check("sr_left", 32'(xl), 32'h2468);
    check("sr_right", 32'(xr), 32'hB5C0);
    check("sr_frame_err", 32'(n_ferr - f0), 32'd1);
    send_slot(1'b1, 16'hF0F0, W, 32);
    check("sr_next_left", 32'(xl), 32'h0F0F);
    check("sr_next_right", 32'(xr), 32'hF0F0);

    // Enable dropped for 20 clk in the middle of a left word.
    x0 = n_xfer;
    for (int i = 0; i < 32; i++) begin
      if (i == 8) begin
        fork
          begin
            #1 en_i = 1'b0;
            repeat (20) @(posedge clk);
            #1 en_i = 1'b1;
          end
        join_none
      end
      bit_cycle(1'b0, i[0], 1'b0);
    end
    send_slot(1'b1, 16'hC3C3, W, 32);
    $display("enable drop: pairs emitted=%0d", n_xfer - x0);
    check("en_no_pair", 32'(n_xfer - x0), 32'd0);
    send_frame(16'h1E1E, 16'hE1E1);
    $display("after enable: left=%h right=%h", xl, xr);
    check("en_resume_count", 32'(n_xfer - x0), 32'd1);
    check("en_resume_left", 32'(xl), 32'h1E1E);
    check("en_resume_right", 32'(xr), 32'hE1E1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
